// File: rtl/ats_timer_pkg.sv
// Shared command opcodes and FSM encoding for the ATS adjustable reference timer.
package ats_timer_pkg;

  localparam logic [1:0] CMD_SET  = 2'd0;
  localparam logic [1:0] CMD_STEP = 2'd1;
  localparam logic [1:0] CMD_SLEW = 2'd2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SLEWING = 1'b1
  } state_e;

endpackage

// File: rtl/ats_timer_alarm.sv
// One-shot, wrap-aware compare channel: fires once when the timer reaches or passes its target.
module ats_timer_alarm #(
  parameter int unsigned TIMESTAMP_WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       arm_valid,
  input  logic [TIMESTAMP_WIDTH-1:0] arm_time,
  input  logic [TIMESTAMP_WIDTH-1:0] timer_value,
  output logic                       armed,
  output logic                       fire
);

  logic [TIMESTAMP_WIDTH-1:0] target_q, target_d;
  logic [TIMESTAMP_WIDTH-1:0] diff;
  logic                       armed_q, armed_d;
  logic                       fire_q, fire_d;
  logic                       reached;

  // Half-range compare: a non-negative difference means the target is at or behind the timer.
  always_comb begin
    diff     = timer_value - target_q;
    reached  = armed_q && !diff[TIMESTAMP_WIDTH-1];
    fire_d   = reached;
    armed_d  = armed_q && !reached;
    target_d = target_q;
    if (arm_valid) begin
      armed_d  = 1'b1;
      target_d = arm_time;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      target_q <= '0;
      armed_q  <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      armed_q  <= armed_d;
      fire_q   <= fire_d;
    end
  end

  assign armed = armed_q;
  assign fire  = fire_q;

endmodule

// File: rtl/ats_adjustable_reference_timer.sv
// Free-running picosecond reference timer with rate trim, set/step/slew correction
// and NUM_ALARMS one-shot compare alarms.
module ats_adjustable_reference_timer
  import ats_timer_pkg::*;
#(
  parameter int unsigned TIMESTAMP_WIDTH = 72,
  parameter int unsigned FRAC_WIDTH      = 16,
  parameter int unsigned CLOCK_PERIOD_PS = 8000,
  parameter int unsigned RATE_ADJ_WIDTH  = 24,
  parameter int unsigned SLEW_STEP_PS    = 100,
  parameter int unsigned NUM_ALARMS      = 4,
  localparam int unsigned IDX_W          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rate_adj_valid,
  input  logic [RATE_ADJ_WIDTH-1:0]  rate_adj,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [TIMESTAMP_WIDTH-1:0] cmd_value,
  output logic                       slew_busy,
  input  logic                       alarm_arm_valid,
  input  logic [IDX_W-1:0]           alarm_arm_idx,
  input  logic [TIMESTAMP_WIDTH-1:0] alarm_arm_time,
  output logic [NUM_ALARMS-1:0]      alarm_armed,
  output logic [NUM_ALARMS-1:0]      alarm_fire,
  output logic [TIMESTAMP_WIDTH-1:0] reference_timer_output
);

  localparam int unsigned ACC_W = TIMESTAMP_WIDTH + FRAC_WIDTH;
  localparam logic [ACC_W-1:0] BASE_INC = ACC_W'(CLOCK_PERIOD_PS) << FRAC_WIDTH;
  localparam logic signed [TIMESTAMP_WIDTH-1:0] SLEW_MAX = TIMESTAMP_WIDTH'(SLEW_STEP_PS);
  localparam logic signed [TIMESTAMP_WIDTH-1:0] SLEW_MIN = -SLEW_MAX;

  logic [ACC_W-1:0]                  acc_q, acc_d;
  logic signed [RATE_ADJ_WIDTH-1:0]  rate_q, rate_d;
  state_e                            state_q, state_d;
  logic signed [TIMESTAMP_WIDTH-1:0] slew_rem_q, slew_rem_d;
  logic                              cmd_ready_q, cmd_ready_d;
  logic                              slew_busy_q, slew_busy_d;

  logic                              cmd_accept;
  logic                              load_set;
  logic signed [TIMESTAMP_WIDTH-1:0] corr;
  logic [ACC_W-1:0]                  inc;

  // Next-state: command decode, slew slicing and accumulator update.
  always_comb begin
    state_d    = state_q;
    slew_rem_d = slew_rem_q;
    rate_d     = rate_adj_valid ? rate_adj : rate_q;
    corr       = '0;
    load_set   = 1'b0;
    cmd_accept = cmd_valid && cmd_ready_q;
    inc        = BASE_INC + {{(ACC_W-RATE_ADJ_WIDTH){rate_q[RATE_ADJ_WIDTH-1]}}, rate_q};

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (cmd_op)
            CMD_SET:  load_set = 1'b1;
            CMD_STEP: corr = cmd_value;
            CMD_SLEW: begin
              state_d    = ST_SLEWING;
              slew_rem_d = cmd_value;
            end
            default: ;
          endcase
        end
      end
      ST_SLEWING: begin
        if (slew_rem_q > SLEW_MAX) begin
          corr = SLEW_MAX;
        end else if (slew_rem_q < SLEW_MIN) begin
          corr = SLEW_MIN;
        end else begin
          corr = slew_rem_q;
        end
        slew_rem_d = slew_rem_q - corr;
        if (slew_rem_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SET replaces the nominal increment for its cycle.
    acc_d = load_set ? {cmd_value, {FRAC_WIDTH{1'b0}}}
                     : acc_q + inc + {corr, {FRAC_WIDTH{1'b0}}};

    cmd_ready_d = (state_d == ST_IDLE);
    slew_busy_d = (state_d == ST_SLEWING);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q       <= '0;
      rate_q      <= '0;
      state_q     <= ST_IDLE;
      slew_rem_q  <= '0;
      cmd_ready_q <= 1'b0;
      slew_busy_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      rate_q      <= rate_d;
      state_q     <= state_d;
      slew_rem_q  <= slew_rem_d;
      cmd_ready_q <= cmd_ready_d;
      slew_busy_q <= slew_busy_d;
    end
  end

  assign reference_timer_output = acc_q[ACC_W-1:FRAC_WIDTH];
  assign cmd_ready              = cmd_ready_q;
  assign slew_busy              = slew_busy_q;

  // Alarms compare against the registered timestamp, so a fire lags the output by one cycle.
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    ats_timer_alarm #(
      .TIMESTAMP_WIDTH(TIMESTAMP_WIDTH)
    ) u_alarm (
      .clk        (clk),
      .rstn       (rstn),
      .arm_valid  (alarm_arm_valid && (alarm_arm_idx == IDX_W'(i))),
      .arm_time   (alarm_arm_time),
      .timer_value(reference_timer_output),
      .armed      (alarm_armed[i]),
      .fire       (alarm_fire[i])
    );
  end

endmodule

// File: tb/tb_ats_adjustable_reference_timer.sv
// Directed plus randomized bench for the ATS reference timer, checked every cycle
// against a behavioural model of timestamps, slew correction lists and alarms.
module tb_ats_adjustable_reference_timer;

  localparam int unsigned TW = 72;
  localparam int unsigned FW = 16;
  localparam int unsigned RW = 24;
  localparam int unsigned NA = 4;
  localparam longint PERIOD_PS = 8000;
  localparam longint SLEW_PS   = 100;
  localparam logic [TW-1:0] HALF = {1'b1, {(TW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rstn;
  logic          rate_adj_valid;
  logic [RW-1:0] rate_adj;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [TW-1:0] cmd_value;
  logic          slew_busy;
  logic          alarm_arm_valid;
  logic [1:0]    alarm_arm_idx;
  logic [TW-1:0] alarm_arm_time;
  logic [NA-1:0] alarm_armed;
  logic [NA-1:0] alarm_fire;
  logic [TW-1:0] reference_timer_output;

  always #5 clk = ~clk;

  ats_adjustable_reference_timer dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .rate_adj_valid        (rate_adj_valid),
    .rate_adj              (rate_adj),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_value             (cmd_value),
    .slew_busy             (slew_busy),
    .alarm_arm_valid       (alarm_arm_valid),
    .alarm_arm_idx         (alarm_arm_idx),
    .alarm_arm_time        (alarm_arm_time),
    .alarm_armed           (alarm_armed),
    .alarm_fire            (alarm_fire),
    .reference_timer_output(reference_timer_output)
  );

  // Reference model state: time in 2^-16 ps, pending slew corrections as a list.
  logic [TW+FW-1:0] m_acc;
  int               m_rate;
  longint           m_slew[$];
  logic             m_live;
  logic [NA-1:0]    m_armed;
  logic [NA-1:0]    m_fire;
  logic [TW-1:0]    m_target [NA];

  int n_checks;
  int n_pass;
  int n_fail;

  logic [TW-1:0] t0;
  logic [TW-1:0] dlt;
  logic [TW-1:0] wrap_v;
  logic          fired;
  int            tmp_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [TW-1:0]        now;
    logic [TW-1:0]        d;
    logic signed [TW-1:0] sv;
    longint               corr;
    longint               rem;
    longint               c;
    logic                 accepted;
    if (!rstn) begin
      m_acc   = '0;
      m_rate  = 0;
      m_slew.delete();
      m_live  = 1'b0;
      m_armed = '0;
      m_fire  = '0;
      for (int i = 0; i < NA; i++) m_target[i] = '0;
      return;
    end
    now = m_acc[TW+FW-1:FW];
    for (int i = 0; i < NA; i++) begin
      d = now - m_target[i];
      m_fire[i] = m_armed[i] && (d < HALF);
      if (m_fire[i]) m_armed[i] = 1'b0;
      if (alarm_arm_valid && int'(alarm_arm_idx) == i) begin
        m_armed[i]  = 1'b1;
        m_target[i] = alarm_arm_time;
      end
    end
    accepted = cmd_valid && m_live && (m_slew.size() == 0);
    corr = 0;
    if (m_slew.size() > 0) corr = m_slew.pop_front();
    sv = cmd_value;
    if (accepted && cmd_op == 2'd0) begin
      m_acc = {cmd_value, {FW{1'b0}}};
    end else begin
      if (accepted && cmd_op == 2'd1) corr = longint'(sv);
      if (accepted && cmd_op == 2'd2) begin
        rem = longint'(sv);
        if (rem == 0) m_slew.push_back(0);
        while (rem != 0) begin
          c = (rem > SLEW_PS) ? SLEW_PS : ((rem < -SLEW_PS) ? -SLEW_PS : rem);
          m_slew.push_back(c);
          rem -= c;
        end
      end
      m_acc = m_acc + 88'(PERIOD_PS) * 88'(65536) + 88'(m_rate) + 88'(corr) * 88'(65536);
    end
    if (rate_adj_valid) m_rate = int'(signed'(rate_adj));
    m_live = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("timer_output", reference_timer_output, m_acc[TW+FW-1:FW]);
    chk("cmd_ready", cmd_ready, m_live && (m_slew.size() == 0));
    chk("slew_busy", slew_busy, m_slew.size() > 0);
    chk("alarm_armed", alarm_armed, m_armed);
    chk("alarm_fire", alarm_fire, m_fire);
    rate_adj_valid  = 1'b0;
    cmd_valid       = 1'b0;
    alarm_arm_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [TW-1:0] v);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_value = v;
  endtask

  task automatic arm(input logic [1:0] idx, input logic [TW-1:0] t);
    alarm_arm_valid = 1'b1;
    alarm_arm_idx   = idx;
    alarm_arm_time  = t;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    rstn            = 1'b0;
    rate_adj_valid  = 1'b0;
    rate_adj        = '0;
    cmd_valid       = 1'b0;
    cmd_op          = '0;
    cmd_value       = '0;
    alarm_arm_valid = 1'b0;
    alarm_arm_idx   = '0;
    alarm_arm_time  = '0;

    // Reset defaults and first ticks
    repeat (3) cycle();
    chk("rst_output", reference_timer_output, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_armed", alarm_armed, 0);
    rstn = 1'b1;
    cycle();
    chk("first_tick", reference_timer_output, 8000);
    chk("ready_after_rst", cmd_ready, 1);
    cycle();
    chk("second_tick", reference_timer_output, 16000);

    // Rate trim: +1 ps/cycle, then -0.5 ps/cycle with fractional carry
    rate_adj_valid = 1'b1;
    rate_adj       = 24'd65536;
    cycle();
    chk("rate_load_cycle", reference_timer_output, 24000);
    cycle();
    chk("rate_plus_one", reference_timer_output, 32001);
    rate_adj_valid = 1'b1;
    rate_adj       = 24'hFF8000;
    cycle();
    for (int k = 0; k < 4; k++) begin
      t0 = reference_timer_output;
      cycle();
      dlt = reference_timer_output - t0;
      chk("rate_frac_delta", dlt, (k % 2 == 0) ? 7999 : 8000);
    end
    rate_adj_valid = 1'b1;
    rate_adj       = '0;
    cycle();

    // SET and STEP
    do_cmd(2'd0, 72'd1000000);
    cycle();
    chk("set_value", reference_timer_output, 1000000);
    cycle();
    chk("set_next", reference_timer_output, 1008000);
    t0 = reference_timer_output;
    do_cmd(2'd1, 72'(-5000));
    cycle();
    dlt = reference_timer_output - t0;
    chk("step_neg_delta", dlt, 3000);
    t0 = reference_timer_output;
    do_cmd(2'd1, 72'd12345);
    cycle();
    dlt = reference_timer_output - t0;
    chk("step_pos_delta", dlt, 20345);

    // SLEW +250 with a blocked SET attempt while busy, then SLEW -250, then SLEW 0
    t0 = reference_timer_output;
    do_cmd(2'd2, 72'd250);
    cycle();
    dlt = reference_timer_output - t0;
    chk("slew_accept_delta", dlt, 8000);
    chk("slew_accept_ready", cmd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) do_cmd(2'd0, '0);
      t0 = reference_timer_output;
      cycle();
      dlt = reference_timer_output - t0;
      chk("slew_pos_delta", dlt, (k == 2) ? 8050 : 8100);
      chk("slew_pos_busy", slew_busy, (k == 2) ? 0 : 1);
      chk("slew_pos_ready", cmd_ready, (k == 2) ? 1 : 0);
    end
    do_cmd(2'd2, 72'(-250));
    cycle();
    for (int k = 0; k < 3; k++) begin
      t0 = reference_timer_output;
      cycle();
      dlt = reference_timer_output - t0;
      chk("slew_neg_delta", dlt, (k == 2) ? 7950 : 7900);
      chk("slew_neg_busy", slew_busy, (k == 2) ? 0 : 1);
    end
    do_cmd(2'd2, '0);
    cycle();
    chk("slew_zero_busy", slew_busy, 1);
    t0 = reference_timer_output;
    cycle();
    dlt = reference_timer_output - t0;
    chk("slew_zero_done", slew_busy, 0);
    chk("slew_zero_delta", dlt, 8000);

    // Alarm channel 2 at 40000 from output 0
    do_cmd(2'd0, '0);
    cycle();
    chk("alarm_base", reference_timer_output, 0);
    arm(2'd2, 72'd40000);
    cycle();
    chk("alarm2_armed", alarm_armed[2], 1);
    fired = 1'b0;
    for (int k = 0; k < 12 && !fired; k++) begin
      t0 = reference_timer_output;
      cycle();
      if (alarm_fire[2]) fired = 1'b1;
    end
    chk("alarm2_fired", fired, 1);
    chk("alarm2_fire_after", t0, 40000);
    chk("alarm2_disarmed", alarm_armed[2], 0);
    cycle();
    chk("alarm2_one_pulse", alarm_fire[2], 0);

    // Past target fires one cycle after arming
    arm(2'd1, 72'd100);
    cycle();
    chk("past_armed", alarm_armed[1], 1);
    chk("past_not_yet", alarm_fire[1], 0);
    cycle();
    chk("past_fire", alarm_fire[1], 1);
    chk("past_disarmed", alarm_armed[1], 0);

    // Re-arm in the same cycle as a fire: pulse for old target, new target stays armed
    arm(2'd0, '0);
    cycle();
    arm(2'd0, reference_timer_output + 72'd1000000);
    cycle();
    chk("rearm_fire", alarm_fire[0], 1);
    chk("rearm_armed", alarm_armed[0], 1);
    cycle();
    chk("rearm_no_refire", alarm_fire[0], 0);

    // Wrap: SET near top of range, target just after wrap
    wrap_v = 72'(-16000);
    do_cmd(2'd0, wrap_v);
    arm(2'd3, 72'd4000);
    cycle();
    chk("wrap_set", reference_timer_output, wrap_v);
    fired = 1'b0;
    for (int k = 0; k < 8 && !fired; k++) begin
      t0 = reference_timer_output;
      cycle();
      if (alarm_fire[3]) fired = 1'b1;
    end
    chk("wrap_fired", fired, 1);
    chk("wrap_fire_after", t0, 8000);

    // Reset mid-slew with armed alarms, one of them due on the reset edge
    arm(2'd3, reference_timer_output + 72'd50000000);
    do_cmd(2'd2, 72'd1000);
    cycle();
    cycle();
    chk("midslew_busy", slew_busy, 1);
    arm(2'd1, reference_timer_output);
    cycle();
    rstn = 1'b0;
    cycle();
    chk("rst_mid_out", reference_timer_output, 0);
    chk("rst_mid_fire", alarm_fire, 0);
    chk("rst_mid_armed", alarm_armed, 0);
    chk("rst_mid_busy", slew_busy, 0);
    cycle();
    rstn = 1'b1;
    cycle();
    chk("post_rst_out", reference_timer_output, 8000);
    chk("post_rst_fire", alarm_fire, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        rate_adj_valid = 1'b1;
        tmp_i          = int'($urandom_range(0, 2097152)) - 1048576;
        rate_adj       = 24'(tmp_i);
      end
      if ($urandom_range(0, 5) == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        case (cmd_op)
          2'd0:    cmd_value = {8'($urandom), $urandom, $urandom};
          2'd1: begin
            tmp_i     = int'($urandom_range(0, 2000000)) - 1000000;
            cmd_value = 72'(tmp_i);
          end
          2'd2: begin
            tmp_i     = int'($urandom_range(0, 4000)) - 2000;
            cmd_value = 72'(tmp_i);
          end
          default: cmd_value = {8'($urandom), $urandom, $urandom};
        endcase
      end
      if ($urandom_range(0, 4) == 0) begin
        tmp_i = int'($urandom_range(0, 400000)) - 100000;
        arm(2'($urandom_range(0, 3)), reference_timer_output + 72'(tmp_i));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
